avalon_mm_fill_checker: RTL and testbench

Avalon-MM master that fills a word-addressed memory region with an incrementing pattern, then reads the region back and counts mismatches. It is the initiator counterpart to the team's 32-bit Avalon slave registers and on-chip memories, and sits on the Qsys fabric as a bus master. A host or other logic starts a run with a pulse and collects the result when `done` pulses.

---
 rtl/avalon_mm_fill_checker.sv | 195 +++++++++++++++++++
 tb/tb_avalon_mm_fill_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_fill_checker.sv
// Avalon-MM master: fills a word region with seed+i, then reads it back and counts mismatches.
// Define READBACK_CHECK_EN to build the READ phase and compare logic; otherwise it only fills.
module avalon_mm_fill_checker #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [CNT_W-1:0] word_count,
   input  logic [31:0]      seed,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [31:0]      first_err_addr,
   output logic [31:0]      avm_address,
   output logic             avm_read,
   output logic             avm_write,
   output logic [31:0]      avm_writedata,
   output logic [3:0]       avm_byteenable,
   input  logic [31:0]      avm_readdata,
   input  logic             avm_waitrequest
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wr_q, wr_d;
   logic             last;

`ifdef READBACK_CHECK_EN
   logic [31:0]      base_q, base_d;
   logic [31:0]      seed_q, seed_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [31:0]      ferr_q, ferr_d;
   logic             rd_q, rd_d;
`else
   logic             unused_readdata;
   assign unused_readdata = ^avm_readdata;
`endif

   assign last = (idx_q == cnt_q - CNT_W'(1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      wr_d    = wr_q;
`ifdef READBACK_CHECK_EN
      base_d  = base_q;
      seed_d  = seed_q;
      err_d   = err_q;
      ferr_d  = ferr_q;
      rd_d    = rd_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               cnt_d  = word_count;
               idx_d  = '0;
               addr_d = base_addr;
               data_d = seed;
`ifdef READBACK_CHECK_EN
               base_d = base_addr;
               seed_d = seed;
               err_d  = '0;
               ferr_d = '0;
`endif
               if (word_count == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_WRITE;
                  wr_d    = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (!avm_waitrequest) begin
               if (last) begin
                  wr_d  = 1'b0;
                  idx_d = '0;
`ifdef READBACK_CHECK_EN
                  state_d = S_READ;
                  rd_d    = 1'b1;
                  addr_d  = base_q;
                  data_d  = seed_q;
`else
                  state_d = S_DONE;
                  done_d  = 1'b1;
`endif
               end else begin
                  idx_d  = idx_q + CNT_W'(1);
                  addr_d = addr_q + 32'd4;
                  data_d = data_q + 32'd1;
               end
            end
         end
`ifdef READBACK_CHECK_EN
         S_READ: begin
            if (!avm_waitrequest) begin
               // data_q doubles as the expected value during readback
               if (avm_readdata != data_q) begin
                  if (err_q != '1) err_d = err_q + CNT_W'(1);
                  if (err_q == '0) ferr_d = addr_q;
               end
               if (last) begin
                  rd_d    = 1'b0;
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_q + CNT_W'(1);
                  addr_d = addr_q + 32'd4;
                  data_d = data_q + 32'd1;
               end
            end
         end
`endif
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wr_q    <= 1'b0;
`ifdef READBACK_CHECK_EN
         base_q  <= '0;
         seed_q  <= '0;
         err_q   <= '0;
         ferr_q  <= '0;
         rd_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wr_q    <= wr_d;
`ifdef READBACK_CHECK_EN
         base_q  <= base_d;
         seed_q  <= seed_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
         rd_q    <= rd_d;
`endif
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign avm_address    = addr_q;
   assign avm_write      = wr_q;
   assign avm_writedata  = data_q;
   assign avm_byteenable = 4'b1111;
`ifdef READBACK_CHECK_EN
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;
   assign avm_read       = rd_q;
`else
   assign err_count      = '0;
   assign first_err_addr = '0;
   assign avm_read       = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_mm_fill_checker.sv
// Directed bench for avalon_mm_fill_checker with a zero-latency memory responder.
// Expected values are hand-computed per run for both readback and fill-only builds.
module tb_avalon_mm_fill_checker;

`ifdef READBACK_CHECK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [15:0] word_count = '0;
   logic [31:0] seed = '0;
   logic        busy, done;
   logic [15:0] err_count;
   logic [31:0] first_err_addr, avm_address, avm_writedata;
   logic        avm_read, avm_write;
   logic [3:0]  avm_byteenable;
   logic [31:0] rdata = '0;
   logic        wreq = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   avalon_mm_fill_checker #(.CNT_W(16)) dut (
      .clock(clock), .resetn(resetn), .start(start),
      .base_addr(base_addr), .word_count(word_count), .seed(seed),
      .busy(busy), .done(done), .err_count(err_count),
      .first_err_addr(first_err_addr), .avm_address(avm_address),
      .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_readdata(rdata), .avm_waitrequest(wreq)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // responder state; decisions are made on the falling edge for the current cycle
   logic [31:0] wlog_a [64];
   logic [31:0] wlog_d [64];
   logic [31:0] rlog_a [64];
   int          wr_n = 0, rd_n = 0;
   int          stall_w = -1, stall_r = -1;
   int          wst_left = 0, rst_left = 0;
   logic [31:0] cmask = '0;
   logic        hold = 1'b0;
   logic [31:0] sv_a = '0, sv_d = '0;

   always @(negedge clock) begin
      wreq  = 1'b0;
      rdata = '0;
      check_eq("rw_excl", {31'b0, avm_read & avm_write}, 32'd0);
      if (avm_write) begin
         check_eq("be", {28'b0, avm_byteenable}, 32'hF);
         if (hold) begin
            check_eq("wstall_addr", avm_address, sv_a);
            check_eq("wstall_data", avm_writedata, sv_d);
         end
         if (wr_n == stall_w && wst_left > 0) begin
            wreq = 1'b1;
            wst_left--;
            hold = 1'b1;
            sv_a = avm_address;
            sv_d = avm_writedata;
         end else begin
            if (wr_n < 64) begin
               wlog_a[wr_n] = avm_address;
               wlog_d[wr_n] = avm_writedata;
            end
            wr_n++;
            hold = 1'b0;
         end
      end else if (avm_read) begin
         if (hold) check_eq("rstall_addr", avm_address, sv_a);
         if (rd_n == stall_r && rst_left > 0) begin
            wreq = 1'b1;
            rst_left--;
            hold = 1'b1;
            sv_a = avm_address;
         end else begin
            if (rd_n < wr_n && rd_n < 64) rdata = wlog_d[rd_n];
            if (rd_n < 32 && cmask[rd_n]) rdata = rdata ^ 32'h0000_0100;
            if (rd_n < 64) rlog_a[rd_n] = avm_address;
            rd_n++;
            hold = 1'b0;
         end
      end else begin
         hold = 1'b0;
      end
   end

   task automatic run(input string tag, input logic [31:0] b,
                      input logic [15:0] n, input logic [31:0] s,
                      input int sw, input int sr, input logic [31:0] cm,
                      input bit repulse, input int done_rb, input int done_nr,
                      input logic [15:0] err_rb, input logic [31:0] ferr_rb);
      int cyc;
      int done_at;
      wr_n = 0; rd_n = 0; hold = 1'b0;
      stall_w = sw; stall_r = sr;
      wst_left = 2; rst_left = 2;
      cmask = cm;
      @(negedge clock);
      base_addr = b; word_count = n; seed = s; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1;
      done_at = -1;
      check_eq({tag, "_busy1"}, {31'b0, busy}, 32'd1);
      while (done_at < 0 && cyc < 300) begin
         if (done) begin
            done_at = cyc;
         end else begin
            if (repulse && cyc == 2) begin
               start = 1'b1;
               base_addr = 32'hDEAD_0000;
               word_count = 16'd7;
               seed = 32'h55;
            end
            @(negedge clock);
            cyc++;
            if (repulse && cyc == 3) start = 1'b0;
         end
      end
      check_eq({tag, "_done_cyc"}, done_at, RB ? done_rb : done_nr);
      check_eq({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
      check_eq({tag, "_err"}, {16'b0, err_count}, RB ? {16'b0, err_rb} : 32'd0);
      check_eq({tag, "_ferr"}, first_err_addr, RB ? ferr_rb : 32'd0);
      @(negedge clock);
      check_eq({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
      check_eq({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
      check_eq({tag, "_err_hold"}, {16'b0, err_count}, RB ? {16'b0, err_rb} : 32'd0);
      check_eq({tag, "_nwr"}, wr_n, {16'b0, n});
      for (int i = 0; i < int'(n) && i < 64; i++) begin
         check_eq({tag, "_waddr"}, wlog_a[i], b + 32'(4 * i));
         check_eq({tag, "_wdata"}, wlog_d[i], s + 32'(i));
      end
      check_eq({tag, "_nrd"}, rd_n, RB ? {16'b0, n} : 32'd0);
      for (int i = 0; i < rd_n && i < 64; i++)
         check_eq({tag, "_raddr"}, rlog_a[i], b + 32'(4 * i));
   endtask

   initial begin
      repeat (2) @(negedge clock);
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_done", {31'b0, done}, 32'd0);
      check_eq("rst_err", {16'b0, err_count}, 32'd0);
      check_eq("rst_ferr", first_err_addr, 32'd0);
      check_eq("rst_addr", avm_address, 32'd0);
      check_eq("rst_wdata", avm_writedata, 32'd0);
      check_eq("rst_wr", {31'b0, avm_write}, 32'd0);
      check_eq("rst_rd", {31'b0, avm_read}, 32'd0);
      check_eq("rst_be", {28'b0, avm_byteenable}, 32'hF);
      resetn = 1'b1;
      @(negedge clock);

      run("basic", 32'h100, 16'd4, 32'hA0, -1, -1, 32'h0, 1'b0,
          9, 5, 16'd0, 32'h0);
      run("stall", 32'h100, 16'd4, 32'hA0, 1, 2, 32'h0, 1'b0,
          13, 7, 16'd0, 32'h0);
      run("corrupt", 32'h100, 16'd4, 32'hA0, -1, -1, 32'hC, 1'b0,
          9, 5, 16'd2, 32'h108);
      run("wrap", 32'hFFFF_FFF8, 16'd3, 32'hFFFF_FFFF, -1, -1, 32'h0, 1'b0,
          7, 4, 16'd0, 32'h0);
      run("zero", 32'h200, 16'd0, 32'h1, -1, -1, 32'h0, 1'b0,
          1, 1, 16'd0, 32'h0);
      run("repulse", 32'h100, 16'd4, 32'hA0, -1, -1, 32'h1, 1'b1,
          9, 5, 16'd1, 32'h100);

      // abandon a run with reset asserted during a stalled write
      wr_n = 0; rd_n = 0; hold = 1'b0;
      stall_w = 0; wst_left = 100; stall_r = -1; cmask = '0;
      base_addr = 32'h300; word_count = 16'd4; seed = 32'h10; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("mrst_wr_pre", {31'b0, avm_write}, 32'd1);
      check_eq("mrst_addr_pre", avm_address, 32'h300);
      resetn = 1'b0;
      #1;
      check_eq("mrst_wr_drop", {31'b0, avm_write}, 32'd0);
      check_eq("mrst_busy_drop", {31'b0, busy}, 32'd0);
      wst_left = 0;
      @(negedge clock);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check_eq("mrst_no_done", {31'b0, done}, 32'd0);
         check_eq("mrst_idle", {31'b0, busy}, 32'd0);
      end
      run("after_rst", 32'h400, 16'd2, 32'h7, -1, -1, 32'h2, 1'b0,
          5, 3, 16'd1, 32'h404);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
